// File: rtl/gpo_seg7_scan.sv
// rtl/gpo_seg7_scan.sv - multiplexed 7-segment scanner for the 32-bit GPO value
module gpo_seg7_scan #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           gpo_in,
    input  logic [7:0]            dp_in,
    input  logic [7:0]            digit_en,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic                  frame_tick
);

    localparam int                    CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [2:0]            IDX_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic                  SEG_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic                  AN_INV    = (AN_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_INV}};
    localparam logic [6:0]            SEG_OFF   = {7{SEG_INV}};

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    state_t                state_q, state_d;
    logic [31:0]           snap_q, snap_d;
    logic [7:0]            snap_dp_q, snap_dp_d;
    logic                  tick_q, tick_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  cnt_wrap;
    logic                  frame_start;
    logic                  show;
    logic [7:0]            onehot;
    logic [3:0]            nibble;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            state_q   <= ST_BLANK;
            snap_q    <= '0;
            snap_dp_q <= '0;
            tick_q    <= 1'b0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= SEG_INV;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            snap_q    <= snap_d;
            snap_dp_q <= snap_dp_d;
            tick_q    <= tick_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    // State follows the next counter value so SHOW coincides with cnt >= BLANK_CYCLES.
    always_comb begin
        cnt_wrap    = (cnt_q == CNT_LAST);
        cnt_d       = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (cnt_d == CNT_BLANK) state_d = ST_SHOW;
            default:  if (cnt_wrap)           state_d = ST_BLANK;
        endcase
        frame_start = (idx_q == 3'd0) && (cnt_q == '0);
        snap_d      = frame_start ? gpo_in : snap_q;
        snap_dp_d   = frame_start ? dp_in  : snap_dp_q;
        tick_d      = frame_start;
    end

    always_comb begin
        show   = (state_q == ST_SHOW) && digit_en[idx_q];
        onehot = 8'd1 << idx_q;
        nibble = snap_q[{idx_q, 2'b00} +: 4];
        an_d   = show ? (onehot[NUM_DIGITS-1:0] ^ AN_OFF) : AN_OFF;
        seg_d  = (show ? hex7(nibble) : 7'h00) ^ SEG_OFF;
        dp_d   = (show & snap_dp_q[idx_q]) ^ SEG_INV;
    end

    assign an_out     = an_q;
    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_gpo_seg7_scan.sv
// tb/tb_gpo_seg7_scan.sv - scoreboard bench for gpo_seg7_scan
module tb_gpo_seg7_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] gpo_in = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  digit_en = '0;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [7:0]  an_out;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        int         start;
        int         len;
    } slot_t;

    slot_t exp_q[$];
    slot_t got_q[$];
    int    multi_cnt;
    int    glitch_cnt;
    bit    frame_timeout;
    logic  next_tick;

    gpo_seg7_scan #(
        .NUM_DIGITS(8), .SCAN_DIV(16), .BLANK_CYCLES(4),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .gpo_in(gpo_in), .dp_in(dp_in),
        .digit_en(digit_en), .seg_out(seg_out), .dp_out(dp_out),
        .an_out(an_out), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] hex_ref(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    // Expected slot records relative to the frame_tick cycle (t=0).
    function automatic void push_frame(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en);
        slot_t      s;
        logic [6:0] h;
        for (int k = 0; k < 8; k++) begin
            if (en[k]) begin
                h       = hex_ref(v[4*k +: 4]);
                s.an    = ~(8'd1 << k);
                s.seg   = ~h;
                s.dp    = ~dp[k];
                s.start = 16 * k + 4;
                s.len   = 12;
                exp_q.push_back(s);
            end
        end
    endfunction

    task automatic observe_frame(input int change_at, input logic [31:0] new_gpo, output int waited);
        slot_t cur;
        bit    active;
        got_q.delete();
        multi_cnt     = 0;
        glitch_cnt    = 0;
        frame_timeout = 0;
        next_tick     = 1'b0;
        waited        = 0;
        cur           = '{8'hFF, 7'h7F, 1'b1, 0, 0};
        while (frame_tick !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (frame_tick !== 1'b1) begin
            frame_timeout = 1;
        end else begin
            active = 0;
            for (int t = 0; t < 128; t++) begin
                if (t == change_at) gpo_in = new_gpo;
                if (an_out !== 8'hFF) begin
                    if ($countones(~an_out) > 1) multi_cnt++;
                    if (!active) begin
                        cur    = '{an_out, seg_out, dp_out, t, 0};
                        active = 1;
                    end else if (an_out !== cur.an || seg_out !== cur.seg || dp_out !== cur.dp) begin
                        glitch_cnt++;
                    end
                    cur.len++;
                end else if (active) begin
                    got_q.push_back(cur);
                    active = 0;
                end
                @(negedge clk);
            end
            if (active) got_q.push_back(cur);
            next_tick = frame_tick;
        end
    endtask

    task automatic test_reset();
        int bad;
        @(negedge clk);
        checks += 4;
        if (an_out !== 8'hFF)   begin errors++; $display("FAIL reset_an: got %h want ff", an_out); end
        if (seg_out !== 7'h7F)  begin errors++; $display("FAIL reset_seg: got %h want 7f", seg_out); end
        if (dp_out !== 1'b1)    begin errors++; $display("FAIL reset_dp: got %b want 1", dp_out); end
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            gpo_in   = $urandom;
            dp_in    = 8'($urandom);
            digit_en = 8'($urandom);
            @(negedge clk);
            checks++;
            if (an_out !== 8'hFF || seg_out !== 7'h7F || dp_out !== 1'b1 || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: an=%h seg=%h dp=%b tick=%b want ff 7f 1 0",
                         i, an_out, seg_out, dp_out, frame_tick);
            end
        end
    endtask

    task automatic test_scan();
        slot_t e, g;
        int    w;
        gpo_in   = 32'h12345678;
        digit_en = 8'hFF;
        dp_in    = 8'h00;
        rst_n    = 1'b1;
        push_frame(32'h12345678, 8'h00, 8'hFF);
        observe_frame(-1, 32'h0, w);
        checks++;
        if (frame_timeout || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL scan_count: got %0d slots (timeout=%0d) want %0d", got_q.size(), frame_timeout, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '{8'hFF, 7'h7F, 1'b1, -1, 0};
            checks++;
            if (g.an !== e.an || g.seg !== e.seg || g.dp !== e.dp || g.start != e.start || g.len != e.len) begin
                errors++;
                $display("FAIL scan_slot: got an=%h seg=%h dp=%b start=%0d len=%0d want an=%h seg=%h dp=%b start=%0d len=%0d",
                         g.an, g.seg, g.dp, g.start, g.len, e.an, e.seg, e.dp, e.start, e.len);
            end
        end
    endtask

    task automatic test_timing();
        int w;
        observe_frame(-1, 32'h0, w);
        checks += 5;
        if (frame_timeout) begin errors++; $display("FAIL timing_tick_wait: got timeout want tick"); end
        if (w != 0)        begin errors++; $display("FAIL timing_back_to_back: got wait %0d want 0", w); end
        if (next_tick !== 1'b1) begin errors++; $display("FAIL timing_period: got tick=%b at +128 want 1", next_tick); end
        if (multi_cnt != 0) begin errors++; $display("FAIL timing_one_hot: got %0d multi-anode cycles want 0", multi_cnt); end
        if (glitch_cnt != 0 || got_q.size() != 8) begin
            errors++;
            $display("FAIL timing_slots: got glitches=%0d slots=%0d want 0 and 8", glitch_cnt, got_q.size());
        end
    endtask

    task automatic test_freeze();
        slot_t e, g;
        int    w;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) push_frame(32'h12345678, 8'h00, 8'hFF);
            else        push_frame(32'hFFFFFFFF, 8'h00, 8'hFF);
            observe_frame((f == 0) ? 52 : -1, 32'hFFFFFFFF, w);
            checks++;
            if (frame_timeout || got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL freeze_count frame %0d: got %0d slots want %0d", f, got_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = (got_q.size() > 0) ? got_q.pop_front() : '{8'hFF, 7'h7F, 1'b1, -1, 0};
                checks++;
                if (g.an !== e.an || g.seg !== e.seg || g.dp !== e.dp || g.start != e.start || g.len != e.len) begin
                    errors++;
                    $display("FAIL freeze_slot frame %0d: got an=%h seg=%h dp=%b start=%0d len=%0d want an=%h seg=%h dp=%b start=%0d len=%0d",
                             f, g.an, g.seg, g.dp, g.start, g.len, e.an, e.seg, e.dp, e.start, e.len);
                end
            end
        end
    endtask

    task automatic test_digit_en();
        slot_t e, g;
        int    w;
        digit_en = 8'h05;
        dp_in    = 8'h04;
        observe_frame(-1, 32'h0, w);
        push_frame(32'hFFFFFFFF, 8'h04, 8'h05);
        observe_frame(-1, 32'h0, w);
        checks++;
        if (frame_timeout || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL digit_en_count: got %0d slots want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '{8'hFF, 7'h7F, 1'b1, -1, 0};
            checks++;
            if (g.an !== e.an || g.seg !== e.seg || g.dp !== e.dp || g.start != e.start || g.len != e.len) begin
                errors++;
                $display("FAIL digit_en_slot: got an=%h seg=%h dp=%b start=%0d len=%0d want an=%h seg=%h dp=%b start=%0d len=%0d",
                         g.an, g.seg, g.dp, g.start, g.len, e.an, e.seg, e.dp, e.start, e.len);
            end
        end
    endtask

    task automatic test_reset_mid();
        slot_t e, g;
        int    w;
        digit_en = 8'hFF;
        dp_in    = 8'h00;
        gpo_in   = 32'h12345678;
        for (int t = 0; t < 88; t++) @(negedge clk);
        checks++;
        if (an_out !== 8'hDF) begin errors++; $display("FAIL mid_pre_reset_an: got %h want df", an_out); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (an_out !== 8'hFF || seg_out !== 7'h7F || dp_out !== 1'b1 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_dark: an=%h seg=%h dp=%b tick=%b want ff 7f 1 0", an_out, seg_out, dp_out, frame_tick);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_frame(32'h12345678, 8'h00, 8'hFF);
        observe_frame(-1, 32'h0, w);
        checks++;
        if (frame_timeout || w != 1) begin
            errors++;
            $display("FAIL mid_first_tick: got wait %0d (timeout=%0d) want 1", w, frame_timeout);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL mid_count: got %0d slots want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '{8'hFF, 7'h7F, 1'b1, -1, 0};
            checks++;
            if (g.an !== e.an || g.seg !== e.seg || g.dp !== e.dp || g.start != e.start || g.len != e.len) begin
                errors++;
                $display("FAIL mid_slot: got an=%h seg=%h dp=%b start=%0d len=%0d want an=%h seg=%h dp=%b start=%0d len=%0d",
                         g.an, g.seg, g.dp, g.start, g.len, e.an, e.seg, e.dp, e.start, e.len);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_timing();
        test_freeze();
        test_digit_en();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
